// File: rtl/player_input_bank.sv
// player_input_bank: multi-channel player input front end.
// Each channel debounces raw quadrature inputs, decodes a step on every
// debounced A rising edge, and keeps a saturating paddle position plus
// its row bitmap. Channels share no state.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset (0 = reset)
//   enc_a      raw encoder A, one bit per channel
//   enc_b      raw encoder B, one bit per channel
//   width_sel  1 = wide paddle (PADDLE_W+2 rows) for that channel
//   paddle_o   paddle bitmaps, channel i at [i*ROWS +: ROWS]
//   pos_o      top row index per channel, channel i at [i*POSW +: POSW]
//   moved      one-cycle pulse when that channel's pos_o changed
//
// Optional feature: define PLAYER_INPUT_BANK_ACCEL_EN to make same-direction
// steps arriving within ACCEL_WINDOW cycles of each other move two rows.
module player_input_bank #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned HIST_LEN     = 16,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned PADDLE_W     = 3,
  parameter int unsigned ACCEL_WINDOW = 64,
  localparam int unsigned POSW        = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CHANNELS-1:0]      enc_a,
  input  logic [CHANNELS-1:0]      enc_b,
  input  logic [CHANNELS-1:0]      width_sel,
  output logic [CHANNELS*ROWS-1:0] paddle_o,
  output logic [CHANNELS*POSW-1:0] pos_o,
  output logic [CHANNELS-1:0]      moved
);

  localparam int unsigned     W_WIDE  = PADDLE_W + 2;
  localparam logic [POSW-1:0] LIM_N   = POSW'(ROWS - PADDLE_W);
  localparam logic [POSW-1:0] LIM_W   = POSW'(ROWS - W_WIDE);
  localparam logic [POSW-1:0] RST_POS = POSW'((ROWS - PADDLE_W) / 2);
  localparam logic [ROWS-1:0] MASK_N  = {ROWS{1'b1}} >> (ROWS - PADDLE_W);
  localparam logic [ROWS-1:0] MASK_W  = {ROWS{1'b1}} >> (ROWS - W_WIDE);
  localparam logic [ROWS-1:0] RST_MAP = MASK_N << RST_POS;

  // Reject geometries the position arithmetic cannot represent.
  if (HIST_LEN < 2 || W_WIDE > ROWS || ACCEL_WINDOW == 0) begin : g_bad_cfg
    $error("player_input_bank: invalid parameter set");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [HIST_LEN-1:0] hist_a_q, hist_b_q;
    logic                lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d;
    logic                lvl_a_dly_q;
    logic                step_q, step_d;
    logic                dir_up_q;
    logic [POSW-1:0]     pos_q, pos_d, lim, base, amt;
    logic [ROWS-1:0]     map_q, map_d;
    logic                moved_q, moved_d;

    // Debounce uses the pre-edge history; step fires one cycle after the
    // debounced A rise, position follows one cycle later.
    always_comb begin
      lvl_a_d = lvl_a_q;
      lvl_b_d = lvl_b_q;
      if (&hist_a_q)       lvl_a_d = 1'b1;
      else if (~|hist_a_q) lvl_a_d = 1'b0;
      if (&hist_b_q)       lvl_b_d = 1'b1;
      else if (~|hist_b_q) lvl_b_d = 1'b0;
      step_d = lvl_a_q & ~lvl_a_dly_q;
    end

    // Clamp to the current width first, then apply any step with saturation.
    always_comb begin
      lim   = width_sel[c] ? LIM_W : LIM_N;
      base  = (pos_q > lim) ? lim : pos_q;
      pos_d = base;
      if (step_q) begin
        if (dir_up_q) pos_d = (base >= amt) ? base - amt : '0;
        else          pos_d = ((lim - base) >= amt) ? base + amt : lim;
      end
      moved_d = (pos_d != pos_q);
      map_d   = (width_sel[c] ? MASK_W : MASK_N) << pos_d;
    end

`ifdef PLAYER_INPUT_BANK_ACCEL_EN
    localparam int unsigned CNTW = $clog2(ACCEL_WINDOW + 1);
    // cnt_q == 0 means no step seen since reset; otherwise it holds the
    // cycles elapsed since the last step, saturating at ACCEL_WINDOW.
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            last_up_q;

    always_comb begin
      amt   = POSW'(1);
      cnt_d = cnt_q;
      if (step_q && cnt_q != '0 && cnt_q < CNTW'(ACCEL_WINDOW) &&
          last_up_q == dir_up_q)
        amt = POSW'(2);
      if (step_q)
        cnt_d = CNTW'(1);
      else if (cnt_q != '0 && cnt_q < CNTW'(ACCEL_WINDOW))
        cnt_d = cnt_q + CNTW'(1);
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q     <= '0;
        last_up_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (step_q) last_up_q <= dir_up_q;
      end
    end
`else
    assign amt = POSW'(1);
`endif

    always_ff @(posedge clk) begin
      if (!reset) begin
        hist_a_q    <= '0;
        hist_b_q    <= '0;
        lvl_a_q     <= 1'b0;
        lvl_b_q     <= 1'b0;
        lvl_a_dly_q <= 1'b0;
        step_q      <= 1'b0;
        dir_up_q    <= 1'b0;
        pos_q       <= RST_POS;
        map_q       <= RST_MAP;
        moved_q     <= 1'b0;
      end else begin
        hist_a_q    <= {hist_a_q[HIST_LEN-2:0], enc_a[c]};
        hist_b_q    <= {hist_b_q[HIST_LEN-2:0], enc_b[c]};
        lvl_a_q     <= lvl_a_d;
        lvl_b_q     <= lvl_b_d;
        lvl_a_dly_q <= lvl_a_q;
        step_q      <= step_d;
        dir_up_q    <= lvl_b_q;
        pos_q       <= pos_d;
        map_q       <= map_d;
        moved_q     <= moved_d;
      end
    end

    assign paddle_o[c*ROWS +: ROWS] = map_q;
    assign pos_o[c*POSW +: POSW]    = pos_q;
    assign moved[c]                 = moved_q;
  end

endmodule

// File: doc/player_input_bank.md
Name: player_input_bank

Overview:
- Parametrised multi-channel player input front end: per-channel debounce, quadrature step decode and saturating paddle position, all in one block.
- Replaces the separate per-player debounce/encoder/paddle instances in the top level.
- Adds variable channel count, paddle geometry and run-time wide-paddle mode.
- Outputs per-channel paddle bitmaps for the game logic and the screen driver.

Parameters:
- CHANNELS, 2: number of independent player inputs.
- HIST_LEN, 16: debounce history length, in clk cycles.
- ROWS, 16: paddle bitmap width; POSW = clog2(ROWS).
- PADDLE_W, 3: normal paddle length in rows; wide paddle = PADDLE_W+2. Requires PADDLE_W+2 <= ROWS.
- ACCEL_WINDOW, 64: acceleration window in cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
- enc_a  in  CHANNELS  raw encoder A per channel.
- enc_b  in  CHANNELS  raw encoder B per channel.
- width_sel  in  CHANNELS  1 = wide paddle for that channel.
- paddle_o  out  CHANNELS*ROWS  bitmap; channel i occupies bits [i*ROWS +: ROWS].
- pos_o  out  CHANNELS*POSW  top row index of each paddle.
- moved  out  CHANNELS  1-cycle pulse when pos_o of that channel changed.

Behaviour:
- Channels are fully independent; no shared state.
- Debounce (per input): shift register of HIST_LEN samples, shifted every clk. Debounced level register:
  - set to 1 when history is all ones;
  - cleared when history is all zeros;
  - otherwise holds.
  - Evaluated from pre-edge history.
- Step decode: on a debounced A rising edge, emit a 1-cycle registered step pulse.
  - Debounced B = 0: direction +1 (down).
  - Debounced B = 1: direction -1.
  - A falling edges and B edges produce no step.
- Position update, on the cycle after the step pulse; w = PADDLE_W, or PADDLE_W+2 when width_sel = 1:
  - +1 saturates at ROWS-w.
  - -1 saturates at 0.
  - Saturated step: pos unchanged, moved stays 0.
- Width clamp: if pos > ROWS-w (e.g. width_sel just rose), pos is clamped to ROWS-w on the next cycle, with moved=1. A step in the same cycle as a clamp is evaluated against the clamped value.
- Bitmap: paddle_o bits pos..pos+w-1 set. Registered, updated on the same edge as pos_o.
- Latency from a stable raw edge: debounced level after HIST_LEN cycles; position/bitmap after HIST_LEN+2 cycles.
- Reset (any time, including mid-debounce):
  - histories, debounced levels and step pulses cleared;
  - pos = (ROWS-PADDLE_W)/2 (integer division);
  - paddle_o = bitmap of that pos at width PADDLE_W;
  - moved = 0.
  - First post-reset cycle with width_sel=1 applies the clamp rule.

Optional Feature:
- Macro: PLAYER_INPUT_BANK_ACCEL_EN.
- Defined: per channel, a counter tracks cycles since the last step and the direction of that step.
  - If a new step has the same direction and arrives fewer than ACCEL_WINDOW cycles after the previous one, pos moves by 2, with the same saturation and clamp rules. A partial move (e.g. 1 row left before the limit) moves to the limit with moved=1.
  - The counter saturates at ACCEL_WINDOW and is reset to 0 by reset.
- Undefined: every step moves exactly 1; counters absent; ACCEL_WINDOW ignored.

Test Plan (CHANNELS=2, HIST_LEN=4, ROWS=16, PADDLE_W=3 unless noted):
- Reset release, inputs low -> pos_o = 6 per channel, paddle_o[15:0] = 0x01C0, paddle_o[31:16] = 0x01C0, moved = 0.
- Ch0: B=0, A held high >=4 cycles -> exactly HIST_LEN+2 = 6 cycles after the A rise, pos0 = 7, paddle0 = 0x0380, moved[0] pulses once; ch1 unchanged.
- Ch0 A glitch high for 3 cycles then low -> no step, pos0 stays 6, moved = 0 throughout.
- Ch1: 8 down steps from pos 6 -> pos1 = 13, paddle1 = 0xE000; the 8th step gives no moved pulse. Then width_sel[1] = 1 -> next cycle pos1 = 11, paddle1 = 0xF800, moved[1] = 1.
- Ch0: B=1 steps from pos 1 -> 0 then saturate; paddle0 = 0x0007. Assert reset mid-debounce -> all outputs return to reset values and the pending step is discarded.
- With PLAYER_INPUT_BANK_ACCEL_EN, ACCEL_WINDOW=64: two down steps 20 cycles apart from pos 6 -> 7 then 9. A third step 100 cycles later -> 10.
